// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file and its clear sequencer.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry once after reset or on clear_req,
// emitting a zero-write strobe/address for the array write port.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              clear_busy,
  output logic              clear_done
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        // Terminate on the last entry so ptr never wraps inside a sweep.
        if (ptr_q == '1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = ptr_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports with
// write-first bypass, optional hardwired zero entry and a hardware clear sweep.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_commit;

  regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
  );

  // A write to the hardwired zero entry never commits, so it cannot bypass.
  assign wr_commit = write_en && !clear_busy && !(ZERO_REG && (write_addr == '0));

  always_comb begin
    rd1_d = mem_q[read_addr1];
    rd2_d = mem_q[read_addr2];
    if (ZERO_REG && (read_addr1 == '0)) rd1_d = '0;
    if (ZERO_REG && (read_addr2 == '0)) rd2_d = '0;
    if (wr_commit && (write_addr == read_addr1)) rd1_d = write_data;
    if (wr_commit && (write_addr == read_addr2)) rd2_d = write_data;
    if (clear_busy) begin
      rd1_d = '0;
      rd2_d = '0;
    end
  end

  // NOTE: the array has no reset; the clear sweep zeroes it after reset, which
  // keeps it mappable onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_commit) begin
      mem_q[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;

endmodule
